// File: rtl/midi_uart_rx.sv
// Purpose: MIDI 8N1 serial receiver; it turns the 31250-baud line into bytes and tags each one status or data.
// Latency: din_rdy pulses one cycle after the mid-stop-bit sample (about 9.5 bit times after the start edge, plus 3 synchroniser cycles).
// Backpressure: none. The consumer must take each din_rdy pulse; dout/status/data hold until the next good byte.
module midi_uart_rx #(
    parameter int CLKS_PER_BIT = 1600,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] dout,
    output logic       din_rdy,
    output logic       status,
    output logic       data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    // Half a bit lands the start sample mid-bit. Every later sample is one full bit after it, so all samples sit mid-bit.
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_meta;
    logic             rx_s;

    // Two-flop synchroniser. Both flops reset to the idle-high line level so that reset cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM, bit timer, shift register and output registers.
    // cnt restarts on every state change and on every bit sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            dout      <= '0;
            din_rdy   <= 1'b0;
            status    <= 1'b0;
            data      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            din_rdy   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            // The line went high again before mid-bit. Treat it as a glitch and drop it.
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            dout    <= shift;
                            status  <= shift[7];
                            data    <= ~shift[7];
                            din_rdy <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Hold here until the line returns high, so that a held-low line cannot frame bogus bytes.
                    if (rx_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
Serial front end of the MIDI receive path. Deserialises the 31250-baud MIDI line (8N1, LSB first) into bytes. Classifies each byte as status (MSB=1) or data (MSB=0). Presents the byte with a one-cycle ready strobe to the downstream MIDI message-parsing FSM, which consumes din_rdy/status/data and loads dout into its status/data registers.

Parameters:
CLKS_PER_BIT, 1600, system clocks per MIDI bit (50 MHz / 31250); must be even and >= 8.
CNT_W, $clog2(CLKS_PER_BIT), bit-timing counter width.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_in  input  1  raw MIDI serial line (after opto-isolator); idles high; asynchronous to clk
dout  output  8  last correctly received byte; held until next good byte
din_rdy  output  1  one-cycle pulse: new byte valid on dout/status/data
status  output  1  level, = dout[7] of last good byte
data  output  1  level, = ~dout[7] of last good byte
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n); async assert, sync-safe deassert is board-level. Reset asynchronously forces state=IDLE, counters=0, shift=0, sync flops=1, dout=0, din_rdy=0, status=0, data=0, frame_err=0, busy=0. Reset mid-frame abandons the byte, emits no pulse; next falling edge after release starts a clean frame.
- Input sync: rx_in through 2 flops (reset value 1) -> rx_s; all decisions use rx_s only.
- Counter cnt (CNT_W bits) clears on every state change and on every bit sample; otherwise increments.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 -> START.
- START: at cnt==CLKS_PER_BIT/2-1, sample rx_s (mid start bit). 0 -> DATA, bit_idx=0. 1 -> IDLE (glitch rejected, no outputs).
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s. Shift right into shift[7] (LSB first), bit_idx++. After the 8th sample (bit_idx==7) -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1: same edge loads dout<=shift, status<=shift[7], data<=~shift[7], din_rdy<=1; -> IDLE.
  - 0: frame_err<=1, dout/status/data unchanged; -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. Bytes received on a held-low line are not accepted.
- din_rdy and frame_err are high exactly one cycle. They are never high together.
- Timing: E0 is the edge where IDLE sees rx_s==0. Samples occur at:
  - start bit: E0+CLKS_PER_BIT/2
  - data bit k: E0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT
  - stop bit: E0+CLKS_PER_BIT/2+9*CLKS_PER_BIT
  - din_rdy is high in the cycle following the stop sample.
- Back-to-back frames: the IDLE entered after a good stop detects a start bit immediately, with no idle cycles required on the line. Mid-stop sampling leaves half a bit of margin.
- status/data are held levels; the downstream FSM may sample them any cycle after din_rdy until the next din_rdy. Both stay 0 until the first good byte.
- No running-status or message interpretation here; that belongs downstream.
- busy: combinational decode of state != IDLE.

Test Plan:
(Sim with CLKS_PER_BIT=16; line driven at exact bit period; clk 10 ns.)
1. Send 0x90 -> one din_rdy pulse 153±3 clocks after start edge; dout=0x90, status=1, data=0, frame_err never high.
2. Send 0x3C, then 0x7F, back-to-back with no idle between stop and next start -> two din_rdy pulses exactly 160 clocks apart; dout 0x3C then 0x7F; data=1, status=0 after each.
3. Frame 0x45 with stop bit driven 0, line held low 40 clocks, then high -> frame_err one-cycle pulse, no din_rdy. dout/status/data retain previous values. A following good 0x80 is received correctly.
4. Glitch rx_in low for 5 clocks while idle -> busy returns to 0 within 10 clocks; no din_rdy, no frame_err; dout unchanged.
5. Assert rst_n low mid data bit 4 of 0xF8, release, then send 0xF8 -> during reset all outputs 0 immediately (asynchronous, before next clk edge). Exactly one din_rdy after release, dout=0xF8, status=1.
6. Sweep all 256 byte values, random 0-40 idle clocks between frames -> 256 din_rdy pulses, each dout matches sent byte, status==dout[7], data==~dout[7].
